// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: IEEE-754 binary32 to int32/uint32 conversion.
// One request at a time: IDLE -> ALIGN -> ROUND -> DONE -> IDLE, with
// result and flags held in DONE until the consumer takes them.
module fp_to_int_converter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] fp_in,
   input  logic [2:0]  r_mode,
   input  logic        is_unsigned,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] int_out,
   output logic        invalid,
   output logic        inexact
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Encodings 101..111 are not listed here and fall through to truncation.
   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rmode_t;

   state_t state, state_next;

   // Latched request
   logic [31:0] op_fp;
   logic [2:0]  op_mode;
   logic        op_uns;

   // ALIGN results (combinational) and their registered copies
   logic [7:0]  a_exp;
   logic [23:0] a_mant;
   logic [7:0]  a_rsh;
   logic [57:0] a_ext;
   logic [31:0] a_mag;
   logic        a_g, a_r, a_s;
   logic        a_big, a_nan, a_inf;

   logic        al_sign;
   logic [31:0] al_mag;
   logic        al_g, al_r, al_s;
   logic        al_big, al_nan, al_inf;

   // ROUND results (combinational)
   rmode_t      rnd_mode;
   logic        rnd_gx;
   logic        rnd_incr;
   logic [32:0] rnd_mag;
   logic        rnd_ovf;
   logic [31:0] rnd_res;
   logic        rnd_inv;
   logic        rnd_inx;

   // State register; reset aborts any conversion in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            state_next = ST_ROUND;
         end
         ST_ROUND: begin
            state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Request capture; inputs are only sampled on the accepting edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_fp   <= '0;
         op_mode <= '0;
         op_uns  <= 1'b0;
      end else if (state == ST_IDLE && in_valid) begin
         op_fp   <= fp_in;
         op_mode <= r_mode;
         op_uns  <= is_unsigned;
      end
   end

   // Unpack and shift the significand into integer part plus guard/round/sticky
   always_comb begin
      a_exp  = op_fp[30:23];
      a_mant = {(a_exp != 8'd0), op_fp[22:0]};
      a_rsh  = '0;
      a_ext  = '0;
      a_mag  = '0;
      a_g    = 1'b0;
      a_r    = 1'b0;
      a_s    = 1'b0;
      a_big  = 1'b0;
      a_nan  = 1'b0;
      a_inf  = 1'b0;
      if (a_exp == 8'hFF) begin
         a_nan = (op_fp[22:0] != 23'd0);
         a_inf = (op_fp[22:0] == 23'd0);
      end else if (a_exp >= 8'd159) begin
         // Unbiased exponent >= 32: magnitude is at least 2^32
         a_big = 1'b1;
      end else if (a_exp >= 8'd150) begin
         a_mag = {8'd0, a_mant} << (a_exp - 8'd150);
      end else begin
         a_rsh = 8'd150 - a_exp;
         if (a_rsh >= 8'd34) begin
            a_s = (a_mant != 24'd0);
         end else begin
            // 34 zero bits below the significand keep every shifted-out bit
            a_ext = {a_mant, 34'd0} >> a_rsh;
            a_mag = {8'd0, a_ext[57:34]};
            a_g   = a_ext[33];
            a_r   = a_ext[32];
            a_s   = |a_ext[31:0];
         end
      end
   end

   // ALIGN stage register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         al_sign <= 1'b0;
         al_mag  <= '0;
         al_g    <= 1'b0;
         al_r    <= 1'b0;
         al_s    <= 1'b0;
         al_big  <= 1'b0;
         al_nan  <= 1'b0;
         al_inf  <= 1'b0;
      end else if (state == ST_ALIGN) begin
         al_sign <= op_fp[31];
         al_mag  <= a_mag;
         al_g    <= a_g;
         al_r    <= a_r;
         al_s    <= a_s;
         al_big  <= a_big;
         al_nan  <= a_nan;
         al_inf  <= a_inf;
      end
   end

   // Round the magnitude, range-check it 33 bits wide, then apply sign or saturate
   always_comb begin
      rnd_mode = rmode_t'(op_mode);
      rnd_gx   = al_g | al_r | al_s;
      rnd_incr = 1'b0;
      case (rnd_mode)
         RM_RNE:  rnd_incr = al_g & (al_r | al_s | al_mag[0]);
         RM_RTZ:  rnd_incr = 1'b0;
         RM_RDN:  rnd_incr = al_sign & rnd_gx;
         RM_RUP:  rnd_incr = ~al_sign & rnd_gx;
         RM_RMM:  rnd_incr = al_g;
         default: rnd_incr = 1'b0;
      endcase
      rnd_mag = {1'b0, al_mag} + {32'd0, rnd_incr};

      if (al_big) begin
         rnd_ovf = 1'b1;
      end else if (!op_uns) begin
         rnd_ovf = al_sign ? (rnd_mag > 33'h0_8000_0000) : (rnd_mag > 33'h0_7FFF_FFFF);
      end else begin
         rnd_ovf = al_sign ? (rnd_mag != 33'd0) : rnd_mag[32];
      end

      rnd_res = (al_sign && !op_uns) ? (~rnd_mag[31:0] + 32'd1) : rnd_mag[31:0];
      rnd_inv = 1'b0;
      rnd_inx = rnd_gx;

      if (al_nan) begin
         rnd_res = op_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         rnd_inv = 1'b1;
         rnd_inx = 1'b0;
      end else if (al_inf || rnd_ovf) begin
         if (al_sign) begin
            rnd_res = op_uns ? 32'h0000_0000 : 32'h8000_0000;
         end else begin
            rnd_res = op_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         end
         rnd_inv = 1'b1;
         rnd_inx = 1'b0;
      end
   end

   // Result registers: loaded leaving ROUND, held through DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_out <= '0;
         invalid <= 1'b0;
         inexact <= 1'b0;
      end else if (state == ST_ROUND) begin
         int_out <= rnd_res;
         invalid <= rnd_inv;
         inexact <= rnd_inx;
      end
   end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Bench for fp_to_int_converter: directed spec cases, handshake/reset
// scenarios and randomized operands against an arithmetic reference model.
module tb_fp_to_int_converter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] fp_in = '0;
   logic [2:0]  r_mode = '0;
   logic        is_unsigned = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] int_out;
   logic        invalid;
   logic        inexact;

   fp_to_int_converter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .fp_in       (fp_in),
      .r_mode      (r_mode),
      .is_unsigned (is_unsigned),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .int_out     (int_out),
      .invalid     (invalid),
      .inexact     (inexact)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      bit          inv;
      bit          inx;
      int unsigned acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   int   ready_ctl = 0;   // 0 random backpressure, 1 always ready, 2 never ready

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
   endtask

   // Reference: exact value m * 2^p, rounded by comparing the remainder to one half.
   task automatic ref_model(input logic [31:0] f, input logic [2:0] mode, input bit uns,
                            output logic [31:0] res, output bit inv, output bit inx);
      bit     sgn;
      int     ex, p, k, cmp;
      longint m, q, rem, half, v, lo, hi;
      bit     nz, up;
      sgn = f[31];
      ex  = int'(f[30:23]);
      inv = 1'b0;
      inx = 1'b0;
      if (ex == 255) begin
         inv = 1'b1;
         if (f[22:0] != 0 || !sgn) res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         else                      res = uns ? 32'h0000_0000 : 32'h8000_0000;
         return;
      end
      m   = (ex == 0) ? longint'(f[22:0]) : (longint'(f[22:0]) + (longint'(1) << 23));
      p   = ((ex == 0) ? 1 : ex) - 150;
      nz  = 1'b0;
      cmp = -1;
      if (p >= 0) begin
         q = (p > 10) ? (longint'(1) << 40) : (m << p);
      end else begin
         k = -p;
         if (k > 40) begin
            q  = 0;
            nz = (m != 0);
         end else begin
            q    = m >> k;
            rem  = m - (q << k);
            half = longint'(1) << (k - 1);
            nz   = (rem != 0);
            cmp  = (rem < half) ? -1 : ((rem == half) ? 0 : 1);
         end
      end
      case (mode)
         3'd0:    up = nz && (cmp > 0 || (cmp == 0 && q[0]));
         3'd2:    up = sgn && nz;
         3'd3:    up = !sgn && nz;
         3'd4:    up = nz && cmp >= 0;
         default: up = 1'b0;
      endcase
      q  = q + (up ? 1 : 0);
      v  = sgn ? -q : q;
      lo = uns ? 0 : -(longint'(1) << 31);
      hi = uns ? ((longint'(1) << 32) - 1) : ((longint'(1) << 31) - 1);
      if (v > hi) begin
         inv = 1'b1;
         res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      end else if (v < lo) begin
         inv = 1'b1;
         res = uns ? 32'h0000_0000 : 32'h8000_0000;
      end else begin
         res = v[31:0];
         inx = nz;
      end
   endtask

   // Present a request, push its expectation on the accepting cycle
   task automatic send(input logic [31:0] f, input logic [2:0] m, input bit u,
                       input logic [31:0] er, input bit einv, input bit einx);
      exp_t e;
      bit   ok;
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      fp_in       = f;
      r_mode      = m;
      is_unsigned = u;
      ok          = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.res = er;
            e.inv = einv;
            e.inx = einx;
            e.acc = cyc;
            sb.push_back(e);
            ok = 1'b1;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      fp_in       = $urandom;
      r_mode      = 3'($urandom_range(0, 7));
      is_unsigned = 1'($urandom_range(0, 1));
   endtask

   task automatic send_model(input logic [31:0] f, input logic [2:0] m, input bit u);
      logic [31:0] r;
      bit          iv, ix;
      ref_model(f, m, u, r, iv, ix);
      send(f, m, u, r, iv, ix);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (sb.size() == 0) && in_ready;
      end
      if (!done) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   // Consumer backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_ctl)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pop on each new result, check latency, hold stability and release
   initial begin
      exp_t cur;
      bit   in_hold, prev_take;
      in_hold   = 1'b0;
      prev_take = 1'b0;
      cur.res   = '0;
      cur.inv   = 1'b0;
      cur.inx   = 1'b0;
      cur.acc   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_hold   = 1'b0;
            prev_take = 1'b0;
         end else begin
            if (prev_take) begin
               chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
               chk("valid_drops_after_take", {31'd0, out_valid}, 32'd0);
            end
            if (out_valid) begin
               if (!in_hold) begin
                  if (sb.size() == 0) begin
                     chk("unexpected_output", {31'd0, out_valid}, 32'd0);
                  end else begin
                     cur = sb.pop_front();
                     in_hold = 1'b1;
                     chk("latency", cyc, cur.acc + 3);
                     chk("int_out", int_out, cur.res);
                     chk("flags_inv_inx", {30'd0, invalid, inexact}, {30'd0, cur.inv, cur.inx});
                  end
               end else begin
                  chk("hold_int_out", int_out, cur.res);
                  chk("hold_flags", {30'd0, invalid, inexact}, {30'd0, cur.inv, cur.inx});
                  chk("hold_in_ready_low", {31'd0, in_ready}, 32'd0);
               end
               prev_take = out_ready;
               if (out_ready) in_hold = 1'b0;
            end else begin
               prev_take = 1'b0;
            end
         end
      end
   end

   // Main sequence
   initial begin
      logic [31:0] f;
      bit          got;

      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_int_out", int_out, 32'd0);
      chk("rst_flags", {30'd0, invalid, inexact}, 32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Directed cases with hand-derived results
      send(32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
      send(32'h3FC0_0000, 3'd1, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
      send(32'hC020_0000, 3'd0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
      send(32'hC020_0000, 3'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1);
      send(32'hC020_0000, 3'd4, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1);
      send(32'hC020_0000, 3'd3, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
      send(32'h4F00_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
      send(32'h4F00_0000, 3'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      send(32'hCF00_0000, 3'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
      send(32'h7FC0_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
      send(32'hFF80_0000, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      send(32'hBE99_999A, 3'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
      send(32'h0000_0001, 3'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
      send(32'h8000_0000, 3'd3, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
      send(32'h0040_0000, 3'd6, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
      send(32'h4020_0000, 3'd5, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
      send(32'hBF00_0000, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
      send(32'hBF00_0000, 3'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      send(32'h4F7F_FFFF, 3'd0, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b0);
      send(32'h4F80_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      send(32'hCF00_0001, 3'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
      drain();

      // Handshake: result held under backpressure for five cycles
      ready_ctl = 2;
      send(32'h4228_0000, 3'd0, 1'b0, 32'h0000_002A, 1'b0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = out_valid;
      end
      if (!got) chk("valid_timeout", 32'd0, 32'd1);
      repeat (4) @(negedge clk);
      chk("still_valid_under_backpressure", {31'd0, out_valid}, 32'd1);
      ready_ctl = 1;
      drain();

      // Reset while the request sits in ROUND
      send(32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_int_out", int_out, 32'd0);
      chk("midrst_flags", {30'd0, invalid, inexact}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_midrst", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_stale_output", {31'd0, out_valid}, 32'd0);
      end
      send(32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
      drain();

      // Randomized operands with random backpressure
      ready_ctl = 0;
      for (int n = 0; n < 300; n++) begin
         f = $urandom;
         case ($urandom_range(0, 9))
            0:       f[30:23] = 8'd0;
            1:       begin
                        f[30:23] = 8'hFF;
                        if ($urandom_range(0, 1) == 1) f[22:0] = '0;
                     end
            2:       f[30:23] = 8'($urandom_range(155, 160));
            default: f[30:23] = 8'($urandom_range(110, 162));
         endcase
         send_model(f, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Absolute time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", passed, checks);
      $fatal(1);
   end

endmodule

// File: doc/fp_to_int_converter.md
FP_TO_INT_CONVERTER -- requirements
Module: fp_to_int_converter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request present on fp_in/r_mode/is_unsigned.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-005 SHALL have port fp_in, input, 32 bits: IEEE-754 binary32 operand.
REQ-006 SHALL have port r_mode, input, 3 bits: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-007 SHALL have port is_unsigned, input, 1 bit: 0 = int32 result, 1 = uint32 result.
REQ-008 SHALL have port out_valid, output, 1 bit: result/flags valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-010 SHALL have port int_out, output, 32 bits: converted integer.
REQ-011 SHALL have port invalid, output, 1 bit: NaN, infinity or out-of-range operand.
REQ-012 SHALL have port inexact, output, 1 bit: discarded fraction bits nonzero; only when invalid=0.

Function
REQ-013 SHALL implement FSM IDLE -> ALIGN -> ROUND -> DONE -> IDLE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready, latching fp_in, r_mode and is_unsigned.
REQ-015 SHALL in ALIGN unpack sign, exp and {hidden,frac}, with hidden = (exp != 0).
REQ-016 SHALL in ALIGN build a 32-bit integer part plus guard, round and sticky bits from the unbiased exponent (exp-127).
- Left shift when exp-127 >= 23.
- Right shift otherwise.
- Shift distance >= 34 gives integer 0 and sticky = (mantissa != 0).
REQ-017 SHALL in ROUND compute the round-up increment on the magnitude; then negate if sign=1 and the result is signed:
- RNE: G && (R || S || lsb).
- RTZ: 0.
- RDN: sign && (G || R || S).
- RUP: !sign && (G || R || S).
- RMM: G.
REQ-018 SHALL treat r_mode 101-111 as RTZ, with no flag.
REQ-019 SHALL set inexact = G || R || S when the result is in range.
REQ-020 SHALL check range after rounding, with the magnitude held 33 bits wide.
- Signed: valid if positive <= 2^31-1 or negative <= 2^31.
- Unsigned: valid if positive <= 2^32-1 or the rounded magnitude is 0.
REQ-021 SHALL return these saturation values with invalid=1 and inexact=0:
- NaN: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned.
- +inf or positive overflow: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned.
- -inf or negative overflow: 0x80000000 signed, 0x00000000 unsigned.
REQ-022 SHALL treat a negative operand that rounds to magnitude 0 as in range: result 0, inexact per REQ-019.
REQ-023 SHALL return int_out=0 for ±0 and subnormals.
- ±0: inexact=0.
- Subnormals: inexact=1, except where rounding produces 1 (e.g. RUP positive gives 1).
REQ-024 SHALL assert out_valid in DONE, exactly 3 cycles after the accept edge.
REQ-025 SHALL hold int_out, invalid and inexact stable while out_valid=1 && out_ready=0.
REQ-026 SHALL return to IDLE on out_valid && out_ready.
- in_ready rises the following cycle.
- Throughput is one conversion per 4 cycles minimum.
REQ-027 SHALL ignore in_valid outside IDLE; inputs are never sampled mid-operation.

Reset
REQ-028 SHALL on rst_n=0 immediately (asynchronously) set the values below, aborting any in-flight conversion:
- FSM=IDLE, out_valid=0, int_out=0, invalid=0, inexact=0.
- in_ready=1 while rst_n=0 is not required; in_ready=1 from the first clock after deassertion.
REQ-029 SHALL produce no output for a request aborted by reset.

Verification
REQ-030 SHALL cover the 1.5 rounding cases: fp_in=0x3FC00000 (1.5), signed.
- RNE -> 0x00000002, inexact=1, invalid=0.
- RTZ -> 0x00000001, inexact=1.
REQ-031 SHALL cover the -2.5 rounding cases: fp_in=0xC0200000 (-2.5), signed.
- RNE -> 0xFFFFFFFE.
- RDN -> 0xFFFFFFFD.
- RMM -> 0xFFFFFFFD.
- RUP -> 0xFFFFFFFE.
- All with inexact=1.
REQ-032 SHALL cover the ±2^31 boundaries:
- 0x4F000000 signed -> 0x7FFFFFFF, invalid=1.
- 0x4F000000 unsigned -> 0x80000000, exact.
- 0xCF000000 signed -> 0x80000000, invalid=0, inexact=0.
REQ-033 SHALL cover specials:
- 0x7FC00000 signed -> 0x7FFFFFFF, invalid=1.
- 0xFF800000 unsigned -> 0x00000000, invalid=1.
- 0xBE99999A (-0.3) unsigned RTZ -> 0x00000000, invalid=0, inexact=1.
REQ-034 SHALL cover handshake timing with 0x42280000 (42.0) accepted at cycle t:
- out_valid rises at t+3.
- Hold out_ready=0 for 5 cycles: int_out=0x0000002A stable, in_ready=0 throughout.
- in_ready=1 the cycle after out_ready=1.
REQ-035 SHALL cover reset mid-operation: pulse rst_n low in ROUND -> out_valid=0 at once, no stale result after release, next request converts correctly.
